// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter and its future receiver.
// Holds the frame state encoding, the parity mode codes and the frame-length helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    // Whole-frame duration in clock cycles, start bit through last stop bit.
    function automatic int frame_cycles(input int data_bits, input int parity_mode,
                                        input int stop_bits, input int clks_per_bit);
        return (1 + data_bits + ((parity_mode != PARITY_NONE) ? 1 : 0) + stop_bits)
               * clks_per_bit;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Baud divider: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each serial bit.
// A restart pulse realigns the count so the next bit begins on the following cycle.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic tx_clock,
    input  logic tx_reset,
    input  logic restart,
    output logic bit_end
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q + CNT_W'(1);
        if (restart || (count_q == LAST_COUNT)) begin
            count_d = '0;
        end
    end

    always_ff @(posedge tx_clock) begin
        if (tx_reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign bit_end = (count_q == LAST_COUNT);

endmodule

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter with valid/ready intake, optional parity and 1-2 stop bits.
// Every line-side output is registered; tx_ready is decoded from registered state.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 tx_clock,
    input  logic                 tx_reset,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_input,
    output logic                 tx_ready,
    output logic                 tx_output,
    output logic                 tx_busy,
    output logic                 tx_done
);

    generate
        if (DATA_BITS < 5 || DATA_BITS > 9 || CLKS_PER_BIT < 2 ||
            PARITY_MODE < PARITY_NONE || PARITY_MODE > PARITY_ODD ||
            (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_params
            $error("uart_tx_frame: illegal parameter combination");
        end
    endgenerate

    // One index counter walks both the data bits and the stop bits.
    localparam int IDX_W = $clog2(DATA_BITS + 1);
    localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

    uart_state_t           state_q;
    uart_state_t           state_d;
    logic [DATA_BITS-1:0]  shift_q;
    logic [DATA_BITS-1:0]  shift_d;
    logic                  parity_q;
    logic                  parity_d;
    logic [IDX_W-1:0]      idx_q;
    logic [IDX_W-1:0]      idx_d;
    logic                  out_q;
    logic                  out_d;
    logic                  busy_q;
    logic                  busy_d;
    logic                  done_q;
    logic                  done_d;

    logic                  bit_end;
    logic                  last_stop;
    logic                  transfer;

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .tx_clock(tx_clock),
        .tx_reset(tx_reset),
        .restart (transfer),
        .bit_end (bit_end)
    );

    // Accepting during the final stop cycle lets frames run back to back.
    assign last_stop = (state_q == ST_STOP) && bit_end && (idx_q == LAST_STOP);
    assign tx_ready  = !tx_reset && ((state_q == ST_IDLE) || last_stop);
    assign transfer  = tx_valid && tx_ready;

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        idx_d    = idx_q;
        done_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
            end
            ST_START: begin
                if (bit_end) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == LAST_DATA) begin
                        idx_d   = '0;
                        state_d = (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (idx_q == LAST_STOP) begin
                        idx_d   = '0;
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (transfer) begin
            shift_d  = tx_input;
            parity_d = (^tx_input) ^ (PARITY_MODE == PARITY_ODD);
            idx_d    = '0;
            state_d  = ST_START;
        end
    end

    // Line level is derived from the next state so it changes on the same edge.
    always_comb begin
        out_d = 1'b1;
        unique case (state_d)
            ST_IDLE:   out_d = 1'b1;
            ST_START:  out_d = 1'b0;
            ST_DATA:   out_d = shift_d[0];
            ST_PARITY: out_d = parity_d;
            ST_STOP:   out_d = 1'b1;
            default:   out_d = 1'b1;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge tx_clock) begin
        if (tx_reset) begin
            state_q  <= ST_IDLE;
            shift_q  <= '0;
            parity_q <= 1'b0;
            idx_q    <= '0;
            out_q    <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            idx_q    <= idx_d;
            out_q    <= out_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign tx_output = out_q;
    assign tx_busy   = busy_q;
    assign tx_done   = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench: several transmitter configurations exercised one after another,
// each accepted frame predicted as a bit sequence and compared cycle by cycle on the line.
module tb_uart_tx_frame;

    localparam int NCFG = 6;
    localparam int DB_A  [NCFG] = '{8, 8, 8, 7, 9, 5};
    localparam int CPB_A [NCFG] = '{4, 4, 4, 4, 2, 3};
    localparam int PM_A  [NCFG] = '{0, 1, 2, 0, 2, 1};
    localparam int SB_A  [NCFG] = '{1, 1, 1, 2, 2, 1};

    typedef struct {
        logic [15:0] bits;
        int          nbits;
        int          t_xfer;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [NCFG-1:0] valid_v;
    logic [NCFG-1:0] ready_v;
    logic [NCFG-1:0] out_v;
    logic [NCFG-1:0] busy_v;
    logic [NCFG-1:0] done_v;
    logic [8:0]      data_v [NCFG];

    int   cycle = 0;
    int   cur = 0;
    bit   abort;
    int   checks = 0;
    int   failures = 0;
    exp_t q[$];
    bit   in_frame = 1'b0;
    bit   pend = 1'b0;

    always @(posedge clk) cycle <= cycle + 1;

    generate
        for (genvar gi = 0; gi < NCFG; gi++) begin : g_dut
            uart_tx_frame #(
                .DATA_BITS   (DB_A[gi]),
                .CLKS_PER_BIT(CPB_A[gi]),
                .PARITY_MODE (PM_A[gi]),
                .STOP_BITS   (SB_A[gi])
            ) u_dut (
                .tx_clock (clk),
                .tx_reset (rst),
                .tx_valid (valid_v[gi]),
                .tx_input (data_v[gi][DB_A[gi]-1:0]),
                .tx_ready (ready_v[gi]),
                .tx_output(out_v[gi]),
                .tx_busy  (busy_v[gi]),
                .tx_done  (done_v[gi])
            );
        end
    endgenerate

    // Expected line bits for a payload under the active configuration.
    function automatic exp_t model(input logic [8:0] v, input int t);
        exp_t e;
        int   n;
        bit   p;
        e.bits = '1;
        n = 0;
        p = 1'b0;
        e.bits[n] = 1'b0;
        n++;
        for (int i = 0; i < DB_A[cur]; i++) begin
            e.bits[n] = v[i];
            p = p ^ v[i];
            n++;
        end
        if (PM_A[cur] != 0) begin
            e.bits[n] = (PM_A[cur] == 1) ? p : !p;
            n++;
        end
        n = n + SB_A[cur];
        e.nbits  = n;
        e.t_xfer = t;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cfg=%0d cycle=%0d: got %0d, want %0d", name, cur, cycle, act, exp);
        end
    endtask

    task automatic send(input logic [8:0] v, input bit keep, input bit push);
        valid_v[cur] = 1'b1;
        forever begin
            @(negedge clk);
            if (ready_v[cur]) begin
                data_v[cur] = v;
                if (push) q.push_back(model(v, cycle));
                break;
            end
            data_v[cur] = 9'($urandom);
        end
        @(posedge clk);
        #1;
        if (!keep) valid_v[cur] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        while (q.size() != 0 || in_frame || pend) @(posedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        int   k;
        int   len;
        int   lerr;
        int   berr;
        int   rerr;
        bit   prev_rst;
        bit   post;
        k = 0; len = 0; lerr = 0; berr = 0; rerr = 0;
        prev_rst = 1'b0;
        post = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) chk("ready_low_in_reset", 32'(ready_v[cur]), 32'd0);
            if (abort) begin
                in_frame = 1'b0;
                pend = 1'b0;
                chk("no_done_abandoned", 32'(done_v[cur]), 32'd0);
                if (prev_rst) post = 1'b1;
                if (post) begin
                    chk("line_high_after_reset", 32'(out_v[cur]), 32'd1);
                    chk("busy_low_after_reset", 32'(busy_v[cur]), 32'd0);
                end
            end else begin
                post = 1'b0;
                chk("done_pulse", 32'(done_v[cur]), 32'(pend));
                pend = 1'b0;
                if (!in_frame) begin
                    if (out_v[cur] == 1'b0) begin
                        chk("start_has_expected_frame", 32'(q.size() != 0), 32'd1);
                        if (q.size() != 0) begin
                            e = q.pop_front();
                            in_frame = 1'b1;
                            k = 0; lerr = 0; berr = 0; rerr = 0;
                            len = e.nbits * CPB_A[cur];
                            chk("start_latency", 32'(cycle - e.t_xfer), 32'd1);
                        end
                    end else begin
                        chk("idle_busy", 32'(busy_v[cur]), 32'd0);
                        chk("idle_ready", 32'(ready_v[cur]), 32'd1);
                    end
                end
                if (in_frame) begin
                    if (out_v[cur] !== e.bits[k / CPB_A[cur]]) lerr++;
                    if (busy_v[cur] !== 1'b1) berr++;
                    if (ready_v[cur] !== (k == len - 1)) rerr++;
                    k++;
                    if (k == len) begin
                        chk("frame_line_bit_errors", 32'(lerr), 32'd0);
                        chk("frame_busy_errors", 32'(berr), 32'd0);
                        chk("frame_ready_errors", 32'(rerr), 32'd0);
                        in_frame = 1'b0;
                        pend = 1'b1;
                    end
                end
            end
            prev_rst = rst;
            if (cycle > 50000) begin
                $display("FAIL watchdog cycle=%0d: got no completion, want all frames drained", cycle);
                $fatal(1, "bench timed out");
            end
        end
    end

    initial begin : stimulus
        rst = 1'b1;
        abort = 1'b1;
        valid_v = '0;
        foreach (data_v[i]) data_v[i] = '0;
        cur = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        idle(2);
        abort = 1'b0;

        for (int c = 0; c < NCFG; c++) begin
            cur = c;
            case (c)
                0: begin
                    send(9'h0A5, 1'b0, 1'b1);
                    idle(6);
                    send(9'h055, 1'b1, 1'b1);
                    send(9'h0AA, 1'b0, 1'b1);
                    drain();
                    // Abandon a frame of all ones during data bit 3, with valid held through reset.
                    abort = 1'b1;
                    send(9'h1FF, 1'b0, 1'b0);
                    idle(4 * CPB_A[c]);
                    rst = 1'b1;
                    valid_v[c] = 1'b1;
                    data_v[c] = 9'($urandom);
                    idle(2);
                    rst = 1'b0;
                    valid_v[c] = 1'b0;
                    idle(60);
                    abort = 1'b0;
                    send(9'h000, 1'b0, 1'b1);
                end
                1, 2: send(9'h007, 1'b0, 1'b1);
                3:    send(9'h07F, 1'b0, 1'b1);
                default: idle(1);
            endcase
            for (int n = 0; n < 10; n++) begin
                send(9'($urandom), 1'($urandom_range(0, 1)), 1'b1);
                if (!valid_v[c]) idle($urandom_range(0, 4));
            end
            valid_v[c] = 1'b0;
            drain();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
- Parametrised UART transmitter; successor to the fixed 8N1, one-bit-per-clock transmitter.
- Adds configurable data width, an internal baud divider, optional even/odd parity, 1 or 2 stop bits, and a valid/ready input handshake that supports back-to-back frames with no idle gap.
- Sits between a byte source (FIFO or register interface) and the serial line pin.

Parameters:
- DATA_BITS, 8, payload width; legal range 5..9.
- CLKS_PER_BIT, 16, tx_clock cycles per serial bit; legal minimum 2.
- PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, stop-bit count; legal values 1 or 2.

Ports:
- tx_clock  in  1  sole clock.
- tx_reset  in  1  synchronous, active-high reset.
- tx_valid  in  1  source has a frame in tx_input.
- tx_input  in  DATA_BITS  payload; sampled only on handshake.
- tx_ready  out  1  transmitter accepts tx_input this cycle.
- tx_output  out  1  serial line; idles high.
- tx_busy  out  1  frame in progress.
- tx_done  out  1  one-cycle pulse: frame's final stop bit completed.

Behaviour:
- Reset (tx_reset sampled high at a tx_clock edge):
  - tx_output=1, tx_busy=0, tx_done=0.
  - State=IDLE; baud counter=0; bit index=0.
  - tx_ready=0 while tx_reset is high.
- Reset mid-frame:
  - Frame abandoned; tx_output returns to 1 at the next edge.
  - No tx_done pulse for the abandoned frame.
- Handshake:
  - Transfer occurs on any edge where tx_valid && tx_ready.
  - tx_input is latched into the shift register and parity is computed from the latched value.
  - tx_input and tx_valid are ignored when tx_ready=0.
- tx_ready is combinational from registered state:
  - High in IDLE.
  - High in the last clock of the final stop bit.
  - Low otherwise, and low during reset.
- States:
  - IDLE: tx_output=1. On transfer -> START.
  - START: tx_output=0 for CLKS_PER_BIT cycles -> DATA.
  - DATA: DATA_BITS bits, LSB first, each CLKS_PER_BIT cycles; shift right. After bit DATA_BITS-1 -> PARITY if PARITY_MODE!=0, else STOP.
  - PARITY: one bit. Even mode sends XOR of the data bits; odd mode sends its inverse. -> STOP.
  - STOP: tx_output=1 for STOP_BITS*CLKS_PER_BIT cycles. At the end: -> START if a transfer occurs that cycle, else -> IDLE.
- Timing:
  - All outputs are registered.
  - The first start-bit cycle is the cycle after the transfer edge.
  - Frame length = (1 + DATA_BITS + (PARITY_MODE!=0) + STOP_BITS) * CLKS_PER_BIT cycles.
- tx_busy: high from the cycle after transfer through the last stop-bit cycle. It stays high across a back-to-back frame.
- tx_done: pulses for one cycle, the cycle after the final stop-bit cycle, for every completed frame. This includes back-to-back frames, where the pulse coincides with the first START cycle of the next frame.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1; width $clog2(CLKS_PER_BIT).
  - Bit boundary when count == CLKS_PER_BIT-1; wraps to 0.
  - Restarts at 0 on every transfer.
- Simultaneous tx_valid with reset: reset wins; no transfer.
- Illegal parameter values are rejected by an elaboration-time check (generate-time error).

Decomposition:
- Package uart_pkg:
  - State encoding constants (IDLE, START, DATA, PARITY, STOP).
  - PARITY_NONE/EVEN/ODD constants.
  - A frame-length function of the parameters, shared with the future receiver.
- Sub-module uart_baud_tick:
  - Parametrised by CLKS_PER_BIT.
  - Inputs: tx_clock, tx_reset, restart.
  - Output: bit_end pulse.
  - Reused by the receiver.

Test Plan:
- 8N1, CLKS_PER_BIT=4; send 0xA5 with tx_valid one cycle:
  - Line = 0, then 1,0,1,0,0,1,0,1, then 1, each held 4 cycles.
  - tx_done pulses at cycle 41 after the transfer edge.
  - tx_busy high for exactly 40 cycles.
- PARITY_MODE=1, send 0x07 -> parity bit 1. PARITY_MODE=2, send 0x07 -> parity bit 0. Frame length 44 cycles at CLKS_PER_BIT=4.
- STOP_BITS=2, DATA_BITS=7, send 0x7F -> stop high for 8 cycles; tx_ready rises only in the last of those 8.
- Back-to-back: hold tx_valid with 0x55 then 0xAA:
  - Second start bit immediately follows the first frame's stop bit, with zero idle cycles.
  - tx_busy stays high; two tx_done pulses.
- Assert tx_reset during data bit 3 of 0xFF:
  - tx_output=1 the next cycle; tx_busy=0.
  - No tx_done pulse.
  - Next frame 0x00 transmits correctly.
- Change tx_input mid-frame while tx_valid=1 and tx_ready=0 -> transmitted bits unchanged; new value taken only at the next handshake.
